piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter for RS codeword symbols.
- Sits directly upstream of the serial-to-parallel capture stage.
- Accepts N-bit symbols over a valid/ready handshake and shifts each one out MSB-first, one bit per clock.
- Emits a one-cycle symbol strobe coincident with the LSB, so the downstream stage captures on the strobe's rising edge, including the bit present in that cycle. Also tracks codeword boundaries and length errors.

Parameters:
- N, 8, symbol width in bits; must be at least 2 so the strobe returns low between symbols.
- SYMS_PER_CW, 255, expected symbols per codeword (RS n); sets the width of sym_cnt, which is clog2(SYMS_PER_CW+1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  N  parallel symbol
- din_valid  input  1  din/din_last are valid
- din_last  input  1  symbol is the final one of its codeword
- din_ready  output  1  block can accept a symbol this cycle
- serial_out  output  1  serial bit stream, MSB first
- sym_strobe  output  1  high for exactly the cycle carrying each symbol's LSB
- cw_done  output  1  pulse with sym_strobe of a symbol tagged din_last
- len_err  output  1  pulse flagging codeword length mismatch
- busy  output  1  shifter or hold register occupied

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0 except din_ready, which is 1 one cycle after release (register-derived, 0 during reset). Shifter, hold register, bit counter and sym_cnt are cleared. A partially shifted symbol is dropped and never strobed.
- Storage:
  - active shifter: N bits, bit_cnt 0..N-1, tag bit.
  - one hold register: N bits plus tag and hold_valid.
  - din_ready = ~hold_valid, driven from registers, not combinationally from din_valid.
- Accept occurs on a rising edge with din_valid & din_ready.
  - If the shifter is idle, or is presenting its last bit (bit_cnt = N-1) that cycle, the symbol loads directly into the shifter.
  - Otherwise it goes to the hold register.
- When the shifter finishes (bit_cnt = N-1) and hold_valid = 1, the hold register moves into the shifter on that edge and hold_valid clears. din_ready rises the following cycle; no same-cycle refill.
- States:
  - IDLE: shifter empty; serial_out = 0.
  - SHIFT: serial_out = active[N-1-bit_cnt]; bit_cnt increments each cycle.
  - At bit_cnt = N-1: go to SHIFT with bit_cnt = 0 if a symbol is available (hold or direct accept), else IDLE.
- Latency: a symbol accepted on edge E while idle puts its MSB on serial_out for the cycle after E, and its LSB with sym_strobe high in cycle E+N.
- Back-to-back streaming has no bubble: the next MSB immediately follows the previous LSB. Throughput is one symbol per N cycles.
- sym_strobe is a single-cycle pulse per symbol. For N ≥ 2 it is low for the N-1 intervening cycles, which guarantees a distinct rising edge per symbol.
- Codeword tracking:
  - sym_cnt increments on each sym_strobe.
  - On a strobe of a din_last symbol: cw_done = 1 and sym_cnt resets to 0. In that same cycle, len_err = 1 if the incremented count ≠ SYMS_PER_CW.
  - If sym_cnt reaches SYMS_PER_CW on a non-last symbol: len_err = 1 in that strobe cycle and sym_cnt wraps to 0.
- Outputs are all registered. busy = shifter active | hold_valid.
- din and din_last are sampled only on accept; their values when not accepted are ignored.

Test Plan:
- Reset, then single symbol 8'hA5 accepted while idle -> serial_out 1,0,1,0,0,1,0,1 over the next 8 cycles. sym_strobe high only on the 8th. Downstream capture yields 8'hA5. busy drops after that cycle.
- Stream 8'h01, 8'h80, 8'hFF with din_valid held high -> 24 contiguous bits with no gap. sym_strobe pulses at cycles 8, 16, 24 and is low between. din_ready is low while hold is full.
- Codeword of exactly SYMS_PER_CW=4 (parameter override), last tagged on the 4th -> cw_done on the 4th strobe, len_err stays 0, sym_cnt back to 0.
- Length faults with SYMS_PER_CW=4:
  - din_last on the 3rd symbol -> cw_done and len_err on the 3rd strobe.
  - 5 symbols without last -> len_err on the 4th strobe, then counting restarts.
- rst_n asserted mid-symbol (bit 3 of 8'hC3) with hold full -> outputs immediately 0, no sym_strobe for either symbol. The next symbol after release shifts cleanly from its MSB.
- din_valid toggling with gaps of 0, 1 and N+2 cycles -> IDLE re-entered only on gaps; each symbol's latency from accept to LSB strobe is exactly N cycles when the block is idle at accept.

Source files
------------

// File: rtl/piso_tx_if.sv
// -----------------------------------------------------------------------------
// piso_tx_if
//   Symbol handshake bundle between a symbol source and the piso_tx serialiser.
//
//   Signals
//     din        N-bit parallel symbol              (source -> piso_tx)
//     din_valid  din/din_last are valid             (source -> piso_tx)
//     din_last   symbol closes its codeword         (source -> piso_tx)
//     din_ready  piso_tx can take a symbol          (piso_tx -> source)
//
//   Modports
//     master  symbol source side
//     slave   piso_tx side
// -----------------------------------------------------------------------------
interface piso_tx_if #(
    parameter int N = 8
) ();
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_last;
    logic         din_ready;

    modport master (
        output din,
        output din_valid,
        output din_last,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        input  din_last,
        output din_ready
    );
endinterface

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx
//   Parallel-in / serial-out transmitter for RS codeword symbols. Symbols taken
//   over a valid/ready handshake are shifted out MSB first, one bit per clock,
//   with a one-cycle strobe alongside each LSB so the downstream capture stage
//   can latch the whole symbol on the strobe's rising edge. A one-deep hold
//   register lets a source stream back to back with no gap between symbols.
//   Codeword boundaries (din_last) are tracked against SYMS_PER_CW.
//
//   Parameters
//     N            symbol width in bits (>= 2, so the strobe drops between symbols)
//     SYMS_PER_CW  expected symbols per codeword
//
//   Ports
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     s_if        symbol handshake (slave): din, din_valid, din_last, din_ready
//     serial_out  serial bit stream, MSB first
//     sym_strobe  high for the cycle carrying each symbol's LSB
//     cw_done     pulse with the strobe of a din_last symbol
//     len_err     pulse on a codeword length mismatch
//     busy        shifter or hold register occupied
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int N           = 8,
    parameter int SYMS_PER_CW = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    piso_tx_if.slave     s_if,
    output logic         serial_out,
    output logic         sym_strobe,
    output logic         cw_done,
    output logic         len_err,
    output logic         busy
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(SYMS_PER_CW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [CW-1:0] SYMS_C   = CW'(SYMS_PER_CW);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [BW-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [N-1:0]    shift_q,    shift_d;
    logic            tag_q,      tag_d;
    logic [N-1:0]    hold_q,     hold_d;
    logic            hold_tag_q, hold_tag_d;
    logic            hold_vld_q, hold_vld_d;
    logic            ready_q,    ready_d;
    logic [CW-1:0]   sym_cnt_q,  sym_cnt_d;
    logic            serial_q,   serial_d;
    logic            strobe_q,   strobe_d;
    logic            cw_done_q,  cw_done_d;
    logic            len_err_q,  len_err_d;
    logic            busy_q,     busy_d;

    logic            last_bit;
    logic            accept;
    logic [CW-1:0]   cnt_inc;

    // State register: every output is a flop, so the next-state logic below
    // also computes what each output will show in the coming cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tag_q      <= 1'b0;
            hold_q     <= '0;
            hold_tag_q <= 1'b0;
            hold_vld_q <= 1'b0;
            ready_q    <= 1'b0;
            sym_cnt_q  <= '0;
            serial_q   <= 1'b0;
            strobe_q   <= 1'b0;
            cw_done_q  <= 1'b0;
            len_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tag_q      <= tag_d;
            hold_q     <= hold_d;
            hold_tag_q <= hold_tag_d;
            hold_vld_q <= hold_vld_d;
            ready_q    <= ready_d;
            sym_cnt_q  <= sym_cnt_d;
            serial_q   <= serial_d;
            strobe_q   <= strobe_d;
            cw_done_q  <= cw_done_d;
            len_err_q  <= len_err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tag_d      = tag_q;
        hold_d     = hold_q;
        hold_tag_d = hold_tag_q;
        hold_vld_d = hold_vld_q;
        sym_cnt_d  = sym_cnt_q;
        serial_d   = 1'b0;
        strobe_d   = 1'b0;
        cw_done_d  = 1'b0;
        len_err_d  = 1'b0;
        cnt_inc    = '0;

        last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
        // ready_q mirrors ~hold_vld_q, so an accept can never overwrite the hold.
        accept   = s_if.din_valid & ready_q;

        if ((state_q == IDLE) || last_bit) begin
            // Shifter is free (or frees up this edge): refill it with no bubble.
            // A pending hold always wins; ready_q is low then, so no accept races it.
            bit_cnt_d = '0;
            if (hold_vld_q) begin
                state_d    = SHIFT;
                shift_d    = hold_q;
                tag_d      = hold_tag_q;
                hold_vld_d = 1'b0;
            end else if (accept) begin
                state_d = SHIFT;
                shift_d = s_if.din;
                tag_d   = s_if.din_last;
            end else begin
                state_d = IDLE;
            end
        end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (accept) begin
                hold_d     = s_if.din;
                hold_tag_d = s_if.din_last;
                hold_vld_d = 1'b1;
            end
        end

        // Ready comes back only the cycle after the hold drains.
        ready_d = ~hold_vld_d;
        busy_d  = (state_d == SHIFT) | hold_vld_d;

        if (state_d == SHIFT) begin
            serial_d = shift_d[LAST_BIT - bit_cnt_d];
            strobe_d = (bit_cnt_d == LAST_BIT);
        end

        // Codeword accounting happens in the strobe cycle itself.
        if (strobe_d) begin
            cnt_inc = sym_cnt_q + CW'(1);
            if (tag_d) begin
                cw_done_d = 1'b1;
                len_err_d = (cnt_inc != SYMS_C);
                sym_cnt_d = '0;
            end else if (cnt_inc == SYMS_C) begin
                len_err_d = 1'b1;
                sym_cnt_d = '0;
            end else begin
                sym_cnt_d = cnt_inc;
            end
        end
    end

    assign s_if.din_ready = ready_q;
    assign serial_out     = serial_q;
    assign sym_strobe     = strobe_q;
    assign cw_done        = cw_done_q;
    assign len_err        = len_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx
//   Directed bench for piso_tx (N=8, SYMS_PER_CW=4). A negedge monitor plays
//   the downstream capture stage and logs each strobed symbol with its flags
//   and cycle number; the main sequence drives the handshake and compares
//   against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_piso_tx;
    localparam int N    = 8;
    localparam int SYMS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serial_out, sym_strobe, cw_done, len_err, busy;

    piso_tx_if #(.N(N)) bus ();

    piso_tx #(.N(N), .SYMS_PER_CW(SYMS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (bus),
        .serial_out (serial_out),
        .sym_strobe (sym_strobe),
        .cw_done    (cw_done),
        .len_err    (len_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int         cyc = 0;
    int         stray = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] ev_d[$];
    bit         ev_cw[$];
    bit         ev_le[$];
    int         ev_cyc[$];
    int         acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream capture: shift every cycle, latch on the strobe including its bit.
    always @(negedge clk) begin
        cap <= {cap[6:0], serial_out};
        if (sym_strobe) begin
            ev_d.push_back({cap[6:0], serial_out});
            ev_cw.push_back(cw_done);
            ev_le.push_back(len_err);
            ev_cyc.push_back(cyc);
        end else if (cw_done || len_err) begin
            stray <= stray + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ev_d.delete();
        ev_cw.delete();
        ev_le.delete();
        ev_cyc.delete();
        acc_q.delete();
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] d, input logic l, input int gap);
        bit acc;
        int pre;
        acc = 1'b0;
        pre = 0;
        bus.din       = d;
        bus.din_last  = l;
        bus.din_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = bus.din_ready;
            pre = cyc;
            tick();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        else acc_q.push_back(pre);
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        bus.din_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && busy; k++) tick();
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  a5 = 8'hA5;
    logic [23:0] stream = 24'h0180FF;
    logic [7:0]  s2[3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0]  c3 = 8'hC3;
    logic [7:0]  td[19] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                            8'h99, 8'hAA, 8'hBB, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5,
                            8'hD1, 8'hD2, 8'hD3};
    bit          tl[19]  = '{0,0,0,1, 0,0,0,1, 0,0,1, 0,0,0,0,0, 0,0,1};
    bit          tle[19] = '{0,0,0,0, 0,0,0,0, 0,0,1, 0,0,0,1,0, 0,0,0};
    int          gaps[19] = '{0,1,10,0, 0,1,10,1, 0,10,0, 0,0,1,10,0, 1,0,10};

    initial begin
        bit acc;
        int idx;
        int exp_cyc;

        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_serial", serial_out, 1'b0);
        chk("rst_strobe", sym_strobe, 1'b0);
        chk("rst_cw",     cw_done,    1'b0);
        chk("rst_lerr",   len_err,    1'b0);
        chk("rst_busy",   busy,       1'b0);
        chk("rst_ready",  bus.din_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", bus.din_ready, 1'b1);

        // Single symbol A5 from idle
        clear_log();
        bus.din = 8'hA5; bus.din_last = 1'b0; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_bit",    serial_out, a5[7-i]);
            chk("t1_strobe", sym_strobe, (i == 7));
            chk("t1_busy",   busy, 1'b1);
            tick();
        end
        chk("t1_end_busy",   busy, 1'b0);
        chk("t1_end_serial", serial_out, 1'b0);
        chk("t1_end_strobe", sym_strobe, 1'b0);
        chk("t1_nev", ev_d.size(), 1);
        if (ev_d.size() > 0) chk("t1_capture", ev_d[0], 8'hA5);

        // Back-to-back stream 01, 80, FF
        do_reset();
        clear_log();
        idx = 0;
        bus.din = s2[0]; bus.din_last = 1'b0; bus.din_valid = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            acc = bus.din_valid && bus.din_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) bus.din = s2[idx];
                else bus.din_valid = 1'b0;
            end
            if (c <= 24) begin
                chk("t2_bit",    serial_out, stream[24-c]);
                chk("t2_strobe", sym_strobe, (c % 8 == 0));
                chk("t2_ready",  bus.din_ready, (c == 1 || c == 9 || c >= 17));
            end else begin
                chk("t2_end_serial", serial_out, 1'b0);
                chk("t2_end_busy",   busy, 1'b0);
            end
        end
        chk("t2_nev", ev_d.size(), 3);
        for (int k = 0; k < 3 && k < ev_d.size(); k++) chk("t2_capture", ev_d[k], s2[k]);

        // Reset mid-symbol with hold full
        do_reset();
        clear_log();
        send(8'hC3, 1'b0, 0);
        send(8'h5A, 1'b0, 0);
        chk("t5_bit1",  serial_out, c3[6]);
        tick();
        tick();
        chk("t5_bit3",  serial_out, c3[4]);
        chk("t5_busy",  busy, 1'b1);
        chk("t5_ready", bus.din_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_busy",  busy, 1'b0);
        chk("t5_async_ready", bus.din_ready, 1'b0);
        chk("t5_async_ser",   serial_out, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("t5_no_strobe", ev_d.size(), 0);
        chk("t5_idle_busy", busy, 1'b0);
        clear_log();
        send(8'h96, 1'b0, 0);
        chk("t5_msb", serial_out, 1'b1);
        drain();
        chk("t5_nev", ev_d.size(), 1);
        if (ev_d.size() > 0 && acc_q.size() > 0) begin
            chk("t5_capture", ev_d[0], 8'h96);
            chk("t5_latency", ev_cyc[0], acc_q[0] + N);
        end

        // Codeword tracking and gapped streaming
        do_reset();
        clear_log();
        for (int k = 0; k < 19; k++) send(td[k], tl[k], gaps[k]);
        drain();
        chk("cw_nev", ev_d.size(), 19);
        exp_cyc = 0;
        for (int k = 0; k < 19 && k < ev_d.size() && k < acc_q.size(); k++) begin
            chk("cw_data",   ev_d[k],  td[k]);
            chk("cw_done",   ev_cw[k], tl[k]);
            chk("cw_lenerr", ev_le[k], tle[k]);
            if (k == 0 || acc_q[k] + N > exp_cyc + N) exp_cyc = acc_q[k] + N;
            else exp_cyc = exp_cyc + N;
            chk("cw_latency", ev_cyc[k], exp_cyc);
        end
        chk("stray_flags", stray, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
